// File: rtl/pix_transmitter.sv
// Parallel pixel-bus transmitter: frames a 12-bit pixel stream with fv/lv strobes
// on a clk/2 pixel clock, pulling one source word per line-valid period.
module pix_transmitter #(
  parameter int ImageWidth  = 256,
  parameter int ImageHeight = 256,
  parameter int HBlank      = 8,
  parameter int FrameLead   = 4,
  parameter int FrameTail   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        src_ready,
  output logic        src_trigger,
  input  logic [15:0] src_data,
  output logic        pix_dclk,
  output logic [11:0] pix_d,
  output logic        pix_fv,
  output logic        pix_lv,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int CW   = $clog2(ImageWidth + 1);
  localparam int RW   = $clog2(ImageHeight + 1);
  localparam int BMAX = (HBlank > FrameLead) ? ((HBlank > FrameTail) ? HBlank : FrameTail)
                                             : ((FrameLead > FrameTail) ? FrameLead : FrameTail);
  localparam int BW   = $clog2(BMAX + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(ImageWidth - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ImageHeight - 1);
  localparam logic [BW-1:0] LEAD_LAST = BW'(FrameLead - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(HBlank - 1);
  localparam logic [BW-1:0] TAIL_LAST = BW'(FrameTail - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_LINE = 3'd2;
  localparam logic [2:0] S_HBLK = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, start_q, stop_q;
  logic [11:0]   d_q;
  logic          fv_q, lv_q, done_q, under_q;
  logic          stop_pend, start_acc, end_frame, next_line;

  assign busy      = start_q | (state_q != S_IDLE);
  assign stop_pend = stop_q | (cmd_stop & busy);
  assign start_acc = cmd_start & ~busy & ~cmd_stop;

  // Next-period state; only committed on the period boundary (phase_q == 1).
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    blk_d     = blk_q;
    end_frame = 1'b0;
    case (state_q)
      S_IDLE: if (start_q) begin
        state_d = S_LEAD;
        col_d   = '0;
        row_d   = '0;
        blk_d   = '0;
      end
      S_LEAD: if (blk_q == LEAD_LAST) begin
        state_d = S_LINE;
        col_d   = '0;
      end else blk_d = blk_q + 1'b1;
      S_LINE: if (col_q == COL_LAST) begin
        blk_d = '0;
        if (row_q < ROW_LAST) begin
          state_d = S_HBLK;
          row_d   = row_q + 1'b1;
        end else state_d = S_TAIL;
      end else col_d = col_q + 1'b1;
      S_HBLK: if (blk_q == HB_LAST) begin
        state_d = S_LINE;
        col_d   = '0;
      end else blk_d = blk_q + 1'b1;
      S_TAIL: if (blk_q == TAIL_LAST) begin
        state_d   = S_IDLE;
        end_frame = 1'b1;
      end else blk_d = blk_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (stop_pend) begin
      state_d   = S_IDLE;
      col_d     = '0;
      row_d     = '0;
      blk_d     = '0;
      end_frame = 1'b0;
    end
  end

  assign next_line   = (state_d == S_LINE);
  assign src_trigger = phase_q & next_line & src_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      done_q  <= 1'b0;
      if (phase_q) begin
        state_q <= state_d;
        col_q   <= col_d;
        row_q   <= row_d;
        blk_q   <= blk_d;
        start_q <= 1'b0;
        stop_q  <= 1'b0;
        fv_q    <= (state_d != S_IDLE);
        lv_q    <= next_line;
        d_q     <= (next_line & src_ready) ? src_data[11:0] : 12'd0;
        done_q  <= end_frame;
        if (next_line & ~src_ready) under_q <= 1'b1;
      end
      // A stop seen in the boundary cycle is consumed combinationally above.
      if (cmd_stop & busy & ~phase_q) stop_q <= 1'b1;
      if (start_acc) begin
        start_q <= 1'b1;
        under_q <= 1'b0;
      end
    end
  end

  assign pix_dclk = phase_q;
  assign pix_d    = d_q;
  assign pix_fv   = fv_q;
  assign pix_lv   = lv_q;
  assign done     = done_q;
  assign underrun = under_q;

endmodule

// File: tb/tb_pix_transmitter.sv
// Scoreboarded bench for pix_transmitter: stimulus queues expected per-period
// {lv,d} entries, a monitor pops one per fv-high pixel period.
module tb_pix_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        src_ready = 1'b1;
  logic [15:0] src_data = 16'hA001;
  logic        src_trigger, pix_dclk, pix_fv, pix_lv, busy, done, underrun;
  logic [11:0] pix_d;

  always #5 clk = ~clk;

  pix_transmitter #(
    .ImageWidth(4), .ImageHeight(2), .HBlank(2), .FrameLead(1), .FrameTail(1)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .src_ready(src_ready), .src_trigger(src_trigger), .src_data(src_data),
    .pix_dclk(pix_dclk), .pix_d(pix_d), .pix_fv(pix_fv), .pix_lv(pix_lv),
    .busy(busy), .done(done), .underrun(underrun)
  );

  typedef struct packed {logic lv; logic [11:0] d;} per_t;
  per_t expq[$];

  int pass_cnt = 0, chk_cnt = 0;
  int fv_per = 0, lv_per = 0, trig_cnt = 0, done_cnt = 0;
  int k = 1;
  bit drop_en = 0;

  function automatic void check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: one sample per pixel period, taken in the dclk-high half.
  initial begin
    per_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (done) done_cnt++;
      if (pix_dclk) begin
        if (pix_fv) begin
          fv_per++;
          if (pix_lv) lv_per++;
          if (expq.size() == 0) check("unexpected_period", 1, 0);
          else begin
            e = expq.pop_front();
            check("lv", int'(pix_lv), int'(e.lv));
            check("pix_d", int'(pix_d), int'(e.d));
          end
        end else check("idle_lv_d", int'({pix_lv, pix_d}), 0);
      end
    end
  end

  // Source model: advances after each consumed word; upper nibble is junk.
  initial begin
    bit trig_prev;
    trig_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin trig_prev = 0; continue; end
      if (trig_prev) k++;
      src_data = {4'hA, 12'(k)};
      trig_prev = src_trigger;
      if (src_trigger) trig_cnt++;
      if (!pix_dclk) src_ready = !(drop_en && pix_lv && lv_per == 1);
    end
  end

  task automatic clear_stats();
    fv_per = 0; lv_per = 0; trig_cnt = 0; done_cnt = 0; k = 1;
    src_data = 16'hA001;
  endtask

  task automatic push(input logic lv, input logic [11:0] d);
    per_t e;
    e.lv = lv; e.d = d;
    expq.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0][11:0] px);
    push(0, 0);
    for (int i = 0; i < 4; i++) push(1, px[i]);
    push(0, 0); push(0, 0);
    for (int i = 4; i < 8; i++) push(1, px[i]);
    push(0, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("frame_timeout", int'(n < 200), 1);
    repeat (4) @(negedge clk);
  endtask

  // Waits for the dclk-low half of the period showing lv-period number lvn+1.
  task automatic wait_lv(input int lvn, input logic lv);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(!pix_dclk && pix_fv && pix_lv == lv && lv_per == lvn) && n < 200);
    check("wait_timeout", int'(n < 200), 1);
  endtask

  task automatic end_checks(input int t, input int dn, input int ur, input int fv, input int lv);
    check("trig_cnt", trig_cnt, t);
    check("done_cnt", done_cnt, dn);
    check("underrun", int'(underrun), ur);
    check("fv_periods", fv_per, fv);
    check("lv_periods", lv_per, lv);
    check("queue_empty", expq.size(), 0);
    check("busy_end", int'(busy), 0);
  endtask

  initial begin
    logic a;
    int bmax;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic a, b;
    int bmax;
    // Reset state
    #2;
    check("rst_dclk", int'(pix_dclk), 0);
    check("rst_fv_lv_d", int'({pix_fv, pix_lv, pix_d}), 0);
    check("rst_busy_done", int'({busy, done}), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_trig", int'(src_trigger), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); a = pix_dclk;
    @(negedge clk); b = pix_dclk;
    check("dclk_toggle", int'(a != b), 1);

    // Full frame
    clear_stats();
    push_frame({12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    wait_idle();
    end_checks(8, 1, 0, 12, 8);

    // Underrun on the third pixel
    clear_stats();
    drop_en = 1;
    push_frame({12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd0, 12'd2, 12'd1});
    pulse_start();
    wait_idle();
    drop_en = 0;
    end_checks(7, 1, 1, 12, 8);
    repeat (10) @(negedge clk);
    check("underrun_sticky", int'(underrun), 1);

    // Second start during HBlank is ignored; accepted start clears underrun
    clear_stats();
    push_frame({12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});
    pulse_start();
    wait_lv(4, 1'b0);
    @(negedge clk); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    wait_idle();
    end_checks(8, 1, 0, 12, 8);
    repeat (20) @(negedge clk);
    check("no_second_frame", fv_per, 12);

    // Abort at row 1 column 2
    clear_stats();
    push(0, 0);
    for (int i = 1; i <= 4; i++) push(1, 12'(i));
    push(0, 0); push(0, 0);
    for (int i = 5; i <= 7; i++) push(1, 12'(i));
    pulse_start();
    wait_lv(6, 1'b1);
    cmd_stop = 1'b1;
    @(negedge clk); cmd_stop = 1'b0;
    @(negedge clk);
    check("abort_fv_lv", int'({pix_fv, pix_lv}), 0);
    check("abort_busy", int'(busy), 0);
    wait_idle();
    end_checks(7, 0, 0, 10, 7);

    // Simultaneous start and stop while idle
    clear_stats();
    @(negedge clk); cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge clk); cmd_start = 1'b0; cmd_stop = 1'b0;
    bmax = 0;
    repeat (20) begin @(negedge clk); if (busy) bmax = 1; end
    check("simul_busy", bmax, 0);
    check("simul_fv", fv_per, 0);

    // Reset mid-line, then a clean frame
    clear_stats();
    push_frame({12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});
    pulse_start();
    wait_lv(1, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst_fv_lv_d", int'({pix_fv, pix_lv, pix_d}), 0);
    check("mrst_dclk_busy_done", int'({pix_dclk, busy, done}), 0);
    check("mrst_trig", int'(src_trigger), 0);
    expq.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("mrst_no_done", done_cnt, 0);
    repeat (20) @(negedge clk);
    check("mrst_stays_idle", int'({busy, pix_fv}), 0);
    clear_stats();
    push_frame({12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1});
    pulse_start();
    wait_idle();
    end_checks(8, 1, 0, 12, 8);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pix_transmitter.md
PIX_TRANSMITTER -- requirements
Module: pix_transmitter

Interface
REQ-001 SHALL have parameter ImageWidth, default 256: pixels per line, at least 1.
REQ-002 SHALL have parameter ImageHeight, default 256: lines per frame, at least 1.
REQ-003 SHALL have parameter HBlank, default 8: pixel periods with lv=0 between consecutive lines, at least 1.
REQ-004 SHALL have parameter FrameLead, default 4: pixel periods with fv=1, lv=0 before the first line, at least 1.
REQ-005 SHALL have parameter FrameTail, default 4: pixel periods with fv=1, lv=0 after the last line, at least 1.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- cmd_start  in  1  one-cycle pulse: send one frame
- cmd_stop  in  1  one-cycle pulse: abort the frame
- src_ready  in  1  src_data holds a valid word
- src_trigger  out  1  consumes the current src_data word
- src_data  in  16  pixel word; bits [11:0] are used
- pix_dclk  out  1  pixel clock, clk/2
- pix_d  out  12  pixel data
- pix_fv  out  1  frame valid
- pix_lv  out  1  line valid
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse: frame completed
- underrun  out  1  sticky: a pixel was emitted without source data

Function
REQ-007 SHALL drive pix_dclk from a registered phase bit that toggles every clk cycle, both out of reset and while idle.
REQ-008 SHALL treat a pixel period as two clk cycles, dclk low then dclk high.
REQ-009 SHALL update pix_d, pix_fv and pix_lv only at a period boundary (the clk edge where pix_dclk goes 1->0), so that a receiver sampling on the pix_dclk rising edge sees stable data.
REQ-010 SHALL implement the state machine Idle -> Lead -> Line -> HBlank -> Line ... -> Tail -> Idle, with every transition taken only at a period boundary.
REQ-011 SHALL, in Idle, drive pix_fv=0, pix_lv=0, pix_d=0, busy=0.
REQ-012 SHALL latch cmd_start while Idle and begin Lead at the next period boundary; busy SHALL rise with the registered start.
REQ-013 SHALL ignore cmd_start while busy.
REQ-014 SHALL, in Lead, drive pix_fv=1, pix_lv=0 for FrameLead periods, then enter Line.
REQ-015 SHALL, in Line, drive pix_fv=1, pix_lv=1 for ImageWidth periods, counting columns with a counter of width clog2(ImageWidth+1).
REQ-016 SHALL, after a line, enter HBlank if the row count is below ImageHeight-1, otherwise enter Tail.
REQ-017 SHALL count rows with a counter of width clog2(ImageHeight+1).
REQ-018 SHALL, in HBlank, drive pix_fv=1, pix_lv=0, pix_d=0 for HBlank periods, then enter Line.
REQ-019 SHALL, in Tail, drive pix_fv=1, pix_lv=0 for FrameTail periods.
REQ-020 SHALL, at the boundary ending Tail, drive pix_fv=0, pulse done for exactly that one clk cycle, and return to Idle.
REQ-021 SHALL form src_trigger combinationally as (phase==1) AND (the next period is a Line period) AND src_ready; it is therefore high for at most one clk cycle per pixel.
REQ-022 SHALL, at a Line period boundary with src_ready=1, load pix_d with src_data[11:0]; src_data[15:12] SHALL be ignored.
REQ-023 SHALL, at a Line period boundary with src_ready=0, drive pix_d=0, keep src_trigger low, set underrun, and keep the frame timing unchanged.
REQ-024 SHALL clear underrun only on reset or on an accepted cmd_start.
REQ-025 SHALL, on cmd_stop while busy, drive pix_fv=0, pix_lv=0, pix_d=0 at the next period boundary, return to Idle without a done pulse, and assert no further src_trigger.
REQ-026 SHALL give cmd_stop priority over a simultaneous cmd_start.
REQ-027 SHALL ignore cmd_stop while Idle.
REQ-028 SHALL emit exactly ImageWidth*ImageHeight line-valid periods per completed frame, whether or not underrun occurs.

Reset
REQ-029 SHALL, on rst=1, immediately (asynchronously) force state=Idle, phase=0, all counters=0, and outputs pix_dclk=0, pix_d=0, pix_fv=0, pix_lv=0, busy=0, done=0, underrun=0.
REQ-030 SHALL resume pix_dclk toggling on the first clk edge after rst deasserts.
REQ-031 SHALL, when reset is asserted mid-frame, drop pix_fv and pix_lv within the same cycle and never emit done.

Verification
(All scenarios use ImageWidth=4, ImageHeight=2, HBlank=2, FrameLead=1, FrameTail=1.)
REQ-032 SHALL verify a full frame: src_ready=1, src_data counting 0x0001 upward, pulse cmd_start -> pix_fv high for 12 periods (24 clk); lv pattern 4 high / 2 low / 4 high; pix_d 1,2,3,4 then 5,6,7,8; 8 src_trigger pulses; one done pulse; underrun=0.
REQ-033 SHALL verify underrun: src_ready=0 during the third pixel only -> pix_d=0 for that period, underrun=1 and held, 7 src_trigger pulses, frame length unchanged.
REQ-034 SHALL verify abort: cmd_stop during row 1 column 2 -> pix_fv=pix_lv=0 at the next boundary, busy=0, no done, no further src_trigger.
REQ-035 SHALL verify start while busy: a second cmd_start during HBlank -> ignored, exactly one frame and one done.
REQ-036 SHALL verify reset mid-frame: rst pulsed during Line -> all outputs 0 within the same cycle; a subsequent cmd_start produces a clean full frame.
REQ-037 SHALL verify simultaneous commands: cmd_start and cmd_stop in the same cycle while Idle -> no frame, busy stays 0.
